// File: rtl/mem_port_arbiter.sv
//----------------------------------------------------------------------------
// mem_port_arbiter: shares one single-port SRAM between CPU data accesses (M0)
// and a burst master (M1), with a bound on how long M0 can starve a burst.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              m0_cs,
  input  logic [3:0]        m0_web,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_din,
  output logic              m0_stall,
  output logic [31:0]       m0_rdata,
  output logic              m0_rvalid,
  // Burst port
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [31:0]       m1_addr,
  input  logic [3:0]        m1_len,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic              m1_beat,
  output logic [31:0]       m1_rdata,
  output logic              m1_rvalid,
  output logic              m1_done,
  // SRAM
  output logic              sram_cs,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [31:0]       sram_di,
  input  logic [31:0]       sram_do
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        remain;
  logic              wr;
  logic [SW-1:0]     starve_cnt;
  logic              m0_pend;
  logic              m1_pend;

  logic              m0_go;
  logic              m1_go;

  // Outputs are gated by rst so nothing issues while reset is held.
  always_comb begin
    m0_go = 1'b0;
    m1_go = 1'b0;
    if (!rst) begin
      m0_go = m0_cs && ((state == IDLE) || (starve_cnt < STARVE_LIM));
      m1_go = (state == BURST) && !m0_go;
    end
  end

  assign m0_stall = m0_cs && m1_go;
  assign m1_ack   = !rst && (state == IDLE) && m1_req;
  assign m1_beat  = m1_go;
  assign m1_done  = m1_go && (remain == 4'd0);

  always_comb begin
    sram_cs  = 1'b0;
    sram_web = 4'b1111;
    sram_a   = '0;
    sram_di  = '0;
    if (m0_go) begin
      sram_cs  = 1'b1;
      sram_web = m0_web;
      sram_a   = m0_addr[ADDR_W+1:2];
      sram_di  = m0_din;
    end else if (m1_go) begin
      sram_cs  = 1'b1;
      sram_web = wr ? 4'b0000 : 4'b1111;
      sram_a   = addr;
      sram_di  = wr ? m1_wdata : 32'd0;
    end
  end

  assign m0_rvalid = m0_pend;
  assign m0_rdata  = m0_pend ? sram_do : 32'd0;
  assign m1_rvalid = m1_pend;
  assign m1_rdata  = m1_pend ? sram_do : 32'd0;

  // Byte-offset and high address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                              m1_addr[31:ADDR_W+2], m1_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      remain     <= '0;
      wr         <= 1'b0;
      starve_cnt <= '0;
      m0_pend    <= 1'b0;
      m1_pend    <= 1'b0;
    end else begin
      m0_pend <= m0_go && (m0_web == 4'b1111);
      m1_pend <= m1_go && !wr;
      case (state)
        IDLE: begin
          if (m1_req) begin
            addr       <= m1_addr[ADDR_W+1:2];
            remain     <= m1_len;
            wr         <= m1_write;
            starve_cnt <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (m0_go) begin
            starve_cnt <= starve_cnt + SW'(1);
          end else begin
            starve_cnt <= '0;
            addr       <= addr + ADDR_W'(1);
            remain     <= remain - 4'd1;
            if (remain == 4'd0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, meaning SRAM word-address width.
REQ-002 Parameter STARVE_MAX, default 4, meaning the maximum number of consecutive burst-beat denials caused by M0 before M1 is forced one beat.
REQ-003 clk  in  1  clock; all state updates occur on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 m0_cs  in  1  CPU data access request for this cycle.
REQ-006 m0_web  in  4  CPU byte write enables, active-low; 4'b1111 means read.
REQ-007 m0_addr  in  32  CPU byte address.
REQ-008 m0_din  in  32  CPU write data, already lane-aligned.
REQ-009 m0_stall  out  1  CPU access not issued this cycle; CPU holds its request.
REQ-010 m0_rdata  out  32  CPU read data; m0_rvalid  out  1  m0_rdata is valid.
REQ-011 m1_req  in  1  burst request; m1_write  in  1  1=write burst; m1_addr  in  32  start byte address; m1_len  in  4  beats minus one.
REQ-012 m1_ack  out  1  burst accepted pulse; m1_beat  out  1  M1 beat issued this cycle; m1_wdata  in  32  write beat data.
REQ-013 m1_rdata  out  32; m1_rvalid  out  1; m1_done  out  1  pulse with the last beat issue.
REQ-014 sram_cs  out  1; sram_web  out  4; sram_a  out  ADDR_W; sram_di  out  32; sram_do  in  32 (valid the cycle after a read issue).

Function
REQ-015 FSM states SHALL be IDLE and BURST; reset state IDLE.
REQ-016 IDLE, m0_cs=1: issue M0 (sram_cs=1, sram_web=m0_web, sram_a=m0_addr[ADDR_W+1:2], sram_di=m0_din); m0_stall=0.
REQ-017 IDLE, m1_req=1: latch m1_addr[ADDR_W+1:2], m1_len, m1_write; pulse m1_ack; next state BURST; no M1 beat this cycle; M0 is served the same cycle if m0_cs=1.
REQ-018 BURST, each cycle: if m0_cs=1 and starve_cnt<STARVE_MAX, issue M0, m0_stall=0, starve_cnt+1; otherwise issue an M1 beat, starve_cnt=0.
REQ-019 M1 beat: sram_cs=1, sram_a=latched address, sram_web=4'b0000 and sram_di=m1_wdata for write bursts, sram_web=4'b1111 for read bursts; m1_beat=1.
REQ-020 After each beat, the address SHALL increment by one word, wrapping modulo 2^ADDR_W, and the remaining-beat count SHALL decrement.
REQ-021 Beat with remaining count 0: m1_done=1 the same cycle; next state IDLE; starve_cnt=0.
REQ-022 m0_stall SHALL be 1 exactly when m0_cs=1 and an M1 beat is issued that cycle (combinational).
REQ-023 Read return: a registered owner flag of the read issued in cycle N SHALL assert m0_rvalid or m1_rvalid in cycle N+1 with rdata=sram_do; writes produce no rvalid.
REQ-024 No access issued: sram_cs=0, sram_web=4'b1111, sram_a=0, sram_di=0.
REQ-025 m1_req during BURST SHALL be ignored; m1_addr[1:0] SHALL be ignored; m1_len=15 gives 16 beats.
REQ-026 At most one access SHALL issue per cycle; M0 and M1 never issue in the same cycle.

Reset
REQ-027 While rst=1: state IDLE, starve_cnt=0, pending-read flags cleared; all outputs 0 except sram_web=4'b1111.
REQ-028 Reset mid-burst SHALL abandon the burst without m1_done; a read issued in the reset cycle SHALL return no rvalid.

Verification
REQ-029 M0 read at 0x0000_0010 in IDLE -> sram_a=4, sram_web=1111 the same cycle; m0_rvalid=1 with m0_rdata=sram_do next cycle; m0_stall=0.
REQ-030 m1_req write, m1_addr=0x40, m1_len=3, M0 idle -> m1_ack, then 4 consecutive beats at sram_a=0x10..0x13 with web=0000; m1_done on the 4th beat.
REQ-031 Read burst m1_len=1 with m0_cs held high throughout, STARVE_MAX=4 -> 4 M0 issues, then 1 M1 beat with m0_stall=1, repeated; m1_done after 10 cycles in BURST.
REQ-032 Burst starting at word 2^ADDR_W-2, m1_len=3 -> sram_a sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-033 rst asserted after 2 beats of an 8-beat read burst -> state IDLE, no m1_done, no m1_rvalid afterwards; next m1_req is accepted normally.
